// File: rtl/hilo_div_unit.sv
// HI/LO register file with a multi-cycle radix-2 restoring divider for DIV/DIVU.
// Optional macro HILO_BYPASS_EN adds a same-cycle writeback bypass on the hi/lo outputs.
//
// state | meaning
// IDLE  | no divide in flight; HI/LO only take writeback data
// BUSY  | one shift/subtract iteration per cycle, counter counting down
// FIX   | apply quotient/remainder signs and commit to LO/HI
// DIVZ  | divisor was zero; commit LO = all ones, HI = dividend
module hilo_div_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_hi_WB,
   input  logic                  we_lo_WB,
   input  logic [DATA_WIDTH-1:0] hi_WB,
   input  logic [DATA_WIDTH-1:0] lo_WB,
   input  logic                  div_start,
   input  logic                  div_signed,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   input  logic                  div_cancel,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo,
   output logic                  div_busy,
   output logic                  div_done,
   output logic                  stall_req
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DIVZ} state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] hi_q, lo_q;
   logic [DATA_WIDTH-1:0] quo_q, rem_q, dvs_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  neg_quo_q, neg_rem_q;
   logic                  busy_q, done_q;

   logic                  dvd_neg, dvs_neg;
   logic [DATA_WIDTH-1:0] dvd_abs, dvs_abs;
   logic [DATA_WIDTH:0]   rem_shift, diff;
   logic [DATA_WIDTH-1:0] rem_d, quo_d;
   logic [DATA_WIDTH-1:0] quo_fix, rem_fix;

   always_comb begin
      dvd_neg   = div_signed & dividend[DATA_WIDTH-1];
      dvs_neg   = div_signed & divisor[DATA_WIDTH-1];
      dvd_abs   = dvd_neg ? (~dividend + 1'b1) : dividend;
      dvs_abs   = dvs_neg ? (~divisor + 1'b1) : divisor;
      // partial remainder never exceeds the divisor, so one extra bit holds the shift
      rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
      diff      = rem_shift - {1'b0, dvs_q};
      rem_d     = diff[DATA_WIDTH] ? rem_shift[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
      quo_d     = {quo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
      quo_fix   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
      rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (we_hi_WB) hi_q <= hi_WB;
         if (we_lo_WB) lo_q <= lo_WB;
         // divider commits below override the writeback writes above
         case (state_q)
            S_IDLE: begin
               if (div_start && !div_cancel) begin
                  busy_q <= 1'b1;
                  if (divisor == '0) begin
                     quo_q   <= dividend;
                     state_q <= S_DIVZ;
                  end else begin
                     quo_q     <= dvd_abs;
                     rem_q     <= '0;
                     dvs_q     <= dvs_abs;
                     neg_quo_q <= dvd_neg ^ dvs_neg;
                     neg_rem_q <= dvd_neg;
                     cnt_q     <= CNT_WIDTH'(DATA_WIDTH);
                     state_q   <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (div_cancel) begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  quo_q <= quo_d;
                  rem_q <= rem_d;
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == CNT_WIDTH'(1)) state_q <= S_FIX;
               end
            end
            S_FIX: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
               if (!div_cancel) begin
                  lo_q   <= quo_fix;
                  hi_q   <= rem_fix;
                  done_q <= 1'b1;
               end
            end
            S_DIVZ: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
               if (!div_cancel) begin
                  lo_q   <= '1;
                  hi_q   <= quo_q;
                  done_q <= 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef HILO_BYPASS_EN
   assign hi = we_hi_WB ? hi_WB : hi_q;
   assign lo = we_lo_WB ? lo_WB : lo_q;
`else
   assign hi = hi_q;
   assign lo = lo_q;
`endif

   assign div_busy  = busy_q;
   assign div_done  = done_q;
   assign stall_req = busy_q | (div_start & ~div_cancel);

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Owns the architectural HI/LO registers and supplies them to the execute stage as its un-forwarded `hi`/`lo` operands.
- Accepts HI/LO writes coming back from the writeback stage.
- Contains a multi-cycle radix-2 restoring divider for DIV/DIVU. The execute stage launches it; it stalls the pipeline until the quotient (LO) and remainder (HI) are committed.

Parameters:
- DATA_WIDTH, 32, width of operands, HI and LO.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- we_hi_WB  input  1  writeback-stage HI write enable.
- we_lo_WB  input  1  writeback-stage LO write enable.
- hi_WB  input  DATA_WIDTH  writeback-stage HI data.
- lo_WB  input  DATA_WIDTH  writeback-stage LO data.
- div_start  input  1  one-cycle request from execute stage to begin a divide.
- div_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled with div_start.
- dividend  input  DATA_WIDTH  forwarded rs value; sampled with div_start.
- divisor  input  DATA_WIDTH  forwarded rt value; sampled with div_start.
- div_cancel  input  1  pipeline flush; aborts an in-flight divide.
- hi  output  DATA_WIDTH  architectural HI to execute stage.
- lo  output  DATA_WIDTH  architectural LO to execute stage.
- div_busy  output  1  registered; high while the divider is not IDLE.
- div_done  output  1  registered one-cycle pulse; HI/LO hold the divide result in this cycle.
- stall_req  output  1  combinational; equals div_busy OR (div_start AND NOT div_cancel).

Behaviour:
- Reset, asynchronous on rst low, regardless of divider state:
  - hi = 0, lo = 0.
  - state = IDLE, div_busy = 0, div_done = 0, counter = 0, all internal registers = 0.
- HI/LO writes:
  - we_hi_WB / we_lo_WB write independently on the clock edge.
  - hi/lo outputs are the register contents; there is no internal bypass (but see optional feature).
- States: IDLE, BUSY, FIX, DIVZ.
- IDLE:
  - div_start=1 and div_cancel=0: capture operands.
    - divisor == 0 → DIVZ.
    - Otherwise latch |dividend| and |divisor| (absolute values only when div_signed=1), record the sign of the quotient and the sign of the dividend, load counter = DATA_WIDTH, go to BUSY.
  - div_start while div_cancel=1: ignored.
- BUSY:
  - One restoring shift/subtract iteration per cycle; counter decrements.
  - Go to FIX on the edge where counter reaches 0 (exactly DATA_WIDTH BUSY cycles).
- FIX:
  - Quotient negated if signs differ (signed only).
  - Remainder takes the sign of the dividend.
  - Edge writes LO = quotient, HI = remainder, sets div_done = 1, goes to IDLE.
- DIVZ: edge writes LO = all ones, HI = dividend, sets div_done = 1, goes to IDLE.
- Latency: start sampled at edge 0; result visible and div_done high after edge DATA_WIDTH+1 (33 for the default). Divide-by-zero result is visible after edge 1.
- div_done: cleared on the following edge.
- div_start while div_busy=1: ignored; the in-flight operation continues.
- div_cancel in BUSY/FIX/DIVZ:
  - Next edge goes to IDLE.
  - No HI/LO write, no div_done.
  - A WB write in the same cycle still happens.
- Collision: a divider commit and a WB write to the same register on the same edge → divider value wins (it is the younger instruction).
- Arithmetic is modulo 2^DATA_WIDTH. Signed 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0, with no exception.

Optional Feature:
- Macro: HILO_BYPASS_EN.
- Defined: the hi output equals hi_WB when we_hi_WB=1, otherwise the register; lo behaves the same with lo_WB/we_lo_WB. This is a same-cycle bypass so that execute-stage forwarding only needs to cover the MEM stage.
- Undefined: hi/lo are purely the register contents. Same-cycle WB values appear one cycle later.

Test Plan:
- Reset then WB write: rst low mid-operation → hi=lo=0, div_busy=0, state IDLE; after release, we_hi_WB=1 with hi_WB=0x12345678 → hi=0x12345678 next cycle, lo still 0.
- Unsigned divide: div_start, div_signed=0, dividend=100, divisor=7 → stall_req high the same cycle; div_busy high for 33 cycles; after edge 33 LO=14, HI=2, div_done high exactly one cycle.
- Signed divide: dividend=0xFFFFFFF9 (-7), divisor=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 33 edges. Also dividend=0x80000000, divisor=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: dividend=0x55, divisor=0 → after edge 1 LO=0xFFFFFFFF, HI=0x55, div_done pulse, div_busy low again.
- Cancel and collision:
  - div_cancel at BUSY cycle 10 → HI/LO unchanged, no div_done, IDLE next cycle.
  - Separately, we_lo_WB=1 with lo_WB=0xAAAA on the FIX commit edge → LO holds the quotient, not 0xAAAA.
- Bypass: with HILO_BYPASS_EN, we_hi_WB=1, hi_WB=0xBEEF → hi=0xBEEF in the same cycle. Without the macro, hi shows 0xBEEF only after the edge.
